// File: rtl/ysyx_22050612_mdu_if.sv
// ysyx_22050612_mdu_if: request/response bundle between the core and the M-extension unit.
// The master is the core side; the slave modport is used by ysyx_22050612_mdu.
interface ysyx_22050612_mdu_if #(
  parameter int unsigned XLEN = 64
) ();
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic            word;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [4:0]      rd_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output flush, in_valid, op, word, src1, src2, rd_in, out_ready,
    input  in_ready, out_valid, result, rd_out
  );

  modport slave (
    input  flush, in_valid, op, word, src1, src2, rd_in, out_ready,
    output in_ready, out_valid, result, rd_out
  );
endinterface

// File: rtl/ysyx_22050612_mdu.sv
// ysyx_22050612_mdu: multi-cycle RV64M multiply/divide, one bit per cycle.
// Define YSYX_22050612_MDU_WORD_EN to add the *W (32-bit, sign-extended) variants.
module ysyx_22050612_mdu #(
  parameter int unsigned XLEN = 64
) (
  input logic                clk,
  input logic                rst_n,
  ysyx_22050612_mdu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  localparam int unsigned    CW      = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  op_e             op_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] opb_q;
  logic [XLEN-1:0] result_q;
  logic            sgn_a_q;
  logic            sgn_b_q;
  logic            out_valid_q;
  logic [4:0]      rd_q;

  op_e op_in;
  assign op_in = op_e'(bus.op);

`ifdef YSYX_22050612_MDU_WORD_EN
  logic word_q;
  logic word_in;
  assign word_in = bus.word && (bus.op == 3'd0 || bus.op[2]);
`else
  logic unused_word;
  assign unused_word = bus.word;
`endif

  // ---------------------------------------------------------------- request decode
  logic            a_signed;
  logic            b_signed;
  logic            sgn_a;
  logic            sgn_b;
  logic            fast;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] min_neg;
  logic [XLEN-1:0] lo_init;
  logic [XLEN-1:0] fast_res;
  logic [CW-1:0]   n_init;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_in)
      OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default:   ;
    endcase

    a_ext   = bus.src1;
    b_ext   = bus.src2;
    min_neg = MIN_NEG;
    n_init  = CW'(XLEN);
`ifdef YSYX_22050612_MDU_WORD_EN
    if (word_in) begin
      a_ext   = {{(XLEN-32){a_signed & bus.src1[31]}}, bus.src1[31:0]};
      b_ext   = {{(XLEN-32){b_signed & bus.src2[31]}}, bus.src2[31:0]};
      min_neg = {{(XLEN-31){1'b1}}, 31'd0};
      n_init  = CW'(32);
    end
`endif

    sgn_a   = a_signed & a_ext[XLEN-1];
    sgn_b   = b_signed & b_ext[XLEN-1];
    mag_a   = sgn_a ? -a_ext : a_ext;
    mag_b   = sgn_b ? -b_ext : b_ext;
    lo_init = mag_a;
`ifdef YSYX_22050612_MDU_WORD_EN
    // A 32-step divide must see the dividend MSB first, so park it at the top.
    if (word_in && bus.op[2]) lo_init = mag_a << (XLEN - 32);
`endif

    fast     = 1'b0;
    fast_res = '0;
    if (bus.op[2] && b_ext == '0) begin
      fast     = 1'b1;
      fast_res = bus.op[1] ? a_ext : '1;
    end else if (bus.op[2] && a_signed && a_ext == min_neg && b_ext == '1) begin
      fast     = 1'b1;
      fast_res = bus.op[1] ? '0 : a_ext;
    end
`ifdef YSYX_22050612_MDU_WORD_EN
    if (word_in) fast_res = {{(XLEN-32){fast_res[31]}}, fast_res[31:0]};
`endif
  end

  // ---------------------------------------------------------------- one iteration
  // Multiply: {acc,lo} shifts right, acc accumulates the multiplicand.
  // Divide: {acc,lo} shifts left, acc is the partial remainder, lo collects quotient bits.
  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] acc_d;
  logic [XLEN-1:0] lo_d;

  always_comb begin
    sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    rem_sh = {acc_q, lo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, opb_q};
    if (op_q[2]) begin
      acc_d = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
      lo_d  = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end else begin
      acc_d = sum[XLEN:1];
      lo_d  = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  // ---------------------------------------------------------------- final result
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rmd_s;
  logic [XLEN-1:0]   res_d;

  always_comb begin
    prod   = {acc_d, lo_d};
    prod_s = (sgn_a_q ^ sgn_b_q) ? -prod : prod;
    quo    = lo_d;
`ifdef YSYX_22050612_MDU_WORD_EN
    if (word_q) quo = {{(XLEN-32){1'b0}}, lo_d[31:0]};
`endif
    quo_s  = (sgn_a_q ^ sgn_b_q) ? -quo : quo;
    rmd_s  = sgn_a_q ? -acc_d : acc_d;
    case (op_q)
      OP_MUL:                       res_d = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_d = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res_d = quo_s;
      default:                      res_d = rmd_s;
    endcase
`ifdef YSYX_22050612_MDU_WORD_EN
    if (word_q) begin
      // After 32 right shifts the low product word sits at the top of lo.
      if (op_q == OP_MUL) res_d = {{(XLEN-32){1'b0}}, lo_d[XLEN-1 -: 32]};
      res_d = {{(XLEN-32){res_d[31]}}, res_d[31:0]};
    end
`endif
  end

  // ---------------------------------------------------------------- control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_MUL;
      cnt_q       <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      sgn_a_q     <= 1'b0;
      sgn_b_q     <= 1'b0;
      out_valid_q <= 1'b0;
      rd_q        <= '0;
`ifdef YSYX_22050612_MDU_WORD_EN
      word_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && !bus.flush) begin
            op_q    <= op_in;
            rd_q    <= bus.rd_in;
            sgn_a_q <= sgn_a;
            sgn_b_q <= sgn_b;
            acc_q   <= '0;
            lo_q    <= lo_init;
            opb_q   <= mag_b;
`ifdef YSYX_22050612_MDU_WORD_EN
            word_q  <= word_in;
`endif
            if (fast) begin
              result_q    <= fast_res;
              out_valid_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= DONE;
            end else begin
              cnt_q   <= n_init;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              result_q    <= res_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.flush || bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.rd_out    = rd_q;

endmodule

// File: tb/tb_ysyx_22050612_mdu.sv
// tb_ysyx_22050612_mdu: scoreboard bench for the multiply/divide unit.
// Expected results come from a behavioural model using native SV arithmetic.
module tb_ysyx_22050612_mdu;
  localparam int unsigned XLEN = 64;
`ifdef YSYX_22050612_MDU_WORD_EN
  localparam bit WORD_EN = 1'b1;
`else
  localparam bit WORD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_22050612_mdu_if #(.XLEN(XLEN)) bus ();
  ysyx_22050612_mdu #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [4:0]  rd_next  = 5'd1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input logic w);
    logic signed [127:0] pa, pb;
    logic [127:0]        p;
    logic signed [63:0]  sa, sb, sq;
    logic [31:0]         a32, b32, r32;
    logic signed [31:0]  sa32, sb32, sq32;
    if (WORD_EN && w && (op == 3'd0 || op[2])) begin
      a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
      case (op)
        3'd0: r32 = a32 * b32;
        3'd4: begin
          if (b32 == 0) r32 = '1;
          else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
          else begin sq32 = sa32 / sb32; r32 = sq32; end
        end
        3'd5: r32 = (b32 == 0) ? '1 : a32 / b32;
        3'd6: begin
          if (b32 == 0) r32 = a32;
          else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
          else begin sq32 = sa32 % sb32; r32 = sq32; end
        end
        default: r32 = (b32 == 0) ? a32 : a32 % b32;
      endcase
      return {{32{r32[31]}}, r32};
    end
    sa = a; sb = b;
    case (op)
      3'd0: begin p = {64'd0, a} * {64'd0, b}; return p[63:0]; end
      3'd1: begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; return p[127:64]; end
      3'd2: begin pa = {{64{a[63]}}, a}; pb = {64'd0, b}; p = pa * pb; return p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
        sq = sa / sb; return sq;
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return '0;
        sq = sa % sb; return sq;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int unsigned ref_lat(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input logic w);
    logic        wd;
    logic [63:0] ae, be, mn;
    wd = WORD_EN && w && (op == 3'd0 || op[2]);
    if (wd) begin
      ae = {{32{a[31]}}, a[31:0]}; be = {{32{b[31]}}, b[31:0]}; mn = 64'hFFFF_FFFF_8000_0000;
    end else begin
      ae = a; be = b; mn = 64'h8000_0000_0000_0000;
    end
    if (op[2] && (be == 0 || ((op == 3'd4 || op == 3'd6) && ae == mn && be == '1))) return 1;
    return wd ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return '1;
      3:       return 64'h8000_0000_0000_0000;
      4:       return 64'h7FFF_FFFF_FFFF_FFFF;
      5:       return 64'($urandom_range(0, 100));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------------------------------------------------------- scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb_q.size() == 0) chk("sb_empty", 64'd1, 64'd0);
      else begin
        e = sb_q.pop_front();
        chk("result", bus.result, e.res);
        chk("rd_out", 64'(bus.rd_out), 64'(e.rd));
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic start_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input logic w, input bit push,
                          input logic [63:0] exp);
    int unsigned guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 200) begin @(posedge clk); #1; guard++; end
    chk("idle_wait", 64'(bus.in_ready), 64'd1);
    bus.op = op; bus.src1 = a; bus.src2 = b; bus.rd_in = rd; bus.word = w;
    bus.in_valid = 1'b1;
    @(posedge clk);
    if (push) sb_q.push_back('{res: exp, rd: rd});
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int unsigned exp_lat);
    int unsigned lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic w, input logic [63:0] exp, input int unsigned lat);
    start_op(op, a, b, rd_next, w, 1'b1, exp);
    rd_next = rd_next + 5'd1;
    wait_valid(lat);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [63:0] a, b;
    logic        w;

    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = '0; bus.word = 1'b0;
    bus.src1 = '0; bus.src2 = '0; bus.rd_in = '0; bus.out_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_rd_out", 64'(bus.rd_out), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // directed vectors with hand-derived results
    run_op(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    run_op(3'd3, '1, '1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op(3'd1, '1, '1, 1'b0, 64'd0, 65);
    run_op(3'd2, '1, 64'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op(3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op(3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op(3'd5, 64'd100, 64'd0, 1'b0, '1, 1);
    run_op(3'd7, 64'd100, 64'd0, 1'b0, 64'd100, 1);
    run_op(3'd4, 64'h8000_0000_0000_0000, '1, 1'b0, 64'h8000_0000_0000_0000, 1);
    run_op(3'd6, 64'h8000_0000_0000_0000, '1, 1'b0, 64'd0, 1);
    run_op(3'd5, '1, 64'd3, 1'b0, 64'h5555_5555_5555_5555, 65);
`ifdef YSYX_22050612_MDU_WORD_EN
    run_op(3'd4, 64'h0000_0001_8000_0000, 64'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 33);
    run_op(3'd0, 64'h0000_0000_7FFF_FFFF, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run_op(3'd1, '1, '1, 1'b1, 64'd0, 65);
`else
    run_op(3'd0, 64'h0000_0001_0000_0001, 64'd3, 1'b1, 64'h0000_0003_0000_0003, 65);
`endif

    // result and tag held while the consumer stalls
    bus.out_ready = 1'b0;
    start_op(3'd4, 64'd1000, 64'd7, 5'd17, 1'b0, 1'b1, 64'd142);
    wait_valid(65);
    repeat (10) begin
      chk("hold_result", bus.result, 64'd142);
      chk("hold_rd", 64'(bus.rd_out), 64'd17);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release", 64'(bus.in_ready), 64'd1);

    // flush mid-CALC discards the operation
    start_op(3'd0, 64'd123, 64'd456, 5'd9, 1'b0, 1'b0, 64'd0);
    repeat (5) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (70) @(posedge clk);
    #1 chk("flush_silent", 64'(bus.out_valid), 64'd0);

    // flush in DONE drops the pending result
    bus.out_ready = 1'b0;
    start_op(3'd5, 64'd5, 64'd0, 5'd3, 1'b0, 1'b0, 64'd0);
    wait_valid(1);
    bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    chk("flush_done_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_done_ready", 64'(bus.in_ready), 64'd1);

    // flush alongside in_valid is not an accept
    bus.op = 3'd5; bus.src1 = 64'd9; bus.src2 = 64'd0; bus.word = 1'b0;
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0; bus.flush = 1'b0;
    chk("flush_accept_ready", 64'(bus.in_ready), 64'd1);
    chk("flush_accept_valid", 64'(bus.out_valid), 64'd0);

    // asynchronous reset mid-CALC
    start_op(3'd4, 64'd77777, 64'd3, 5'd21, 1'b0, 1'b0, 64'd0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_result", bus.result, 64'd0);
    chk("arst_rd_out", 64'(bus.rd_out), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // randomised ops against the model
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      w  = 1'($urandom_range(0, 1));
      run_op(op, a, b, w, ref_res(op, a, b, w), ref_lat(op, a, b, w));
    end

    repeat (3) @(posedge clk);
    #1 chk("sb_left", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
